// File: rtl/mux32_8_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux32_8_arbiter_if
// Description : Request/data/handshake bundle between eight sources, the
//               shared-mux arbiter and its single downstream consumer.
// Revision    : 1.0  initial release
// ============================================================================
interface mux32_8_arbiter_if #(
   parameter int WIDTH = 32
);
   logic [7:0]       req;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] e;
   logic [WIDTH-1:0] f;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] h;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [2:0]       sel;
   logic [7:0]       grant;

   // Sources and consumer side
   modport master (
      output req, a, b, c, d, e, f, g, h, out_ready,
      input  out_valid, out_data, sel, grant
   );

   // Arbiter side
   modport slave (
      input  req, a, b, c, d, e, f, g, h, out_ready,
      output out_valid, out_data, sel, grant
   );
endinterface
`default_nettype wire

// File: rtl/mux32_8_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux32_8_arbiter (with helper mux32_8)
// Description : Round-robin scheduler sharing one 8:1 word mux among eight
//               requesters; the captured word leaves through valid/ready.
//               Define MUX_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision    : 1.0  initial release
// ============================================================================

module mux32_8 #(
   parameter int WIDTH = 32
) (
   input  wire logic [WIDTH-1:0] a,
   input  wire logic [WIDTH-1:0] b,
   input  wire logic [WIDTH-1:0] c,
   input  wire logic [WIDTH-1:0] d,
   input  wire logic [WIDTH-1:0] e,
   input  wire logic [WIDTH-1:0] f,
   input  wire logic [WIDTH-1:0] g,
   input  wire logic [WIDTH-1:0] h,
   input  wire logic [2:0]       op,
   output logic      [WIDTH-1:0] out
);
   always_comb begin
      out = a;
      case (op)
         3'd0:    out = a;
         3'd1:    out = b;
         3'd2:    out = c;
         3'd3:    out = d;
         3'd4:    out = e;
         3'd5:    out = f;
         3'd6:    out = g;
         3'd7:    out = h;
         default: out = a;
      endcase
   end
endmodule

module mux32_8_arbiter #(
   parameter int WIDTH = 32
) (
   input  wire logic        clk,
   input  wire logic        reset,
   mux32_8_arbiter_if.slave bus
);
   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_HOLD = 1'b1;

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [WIDTH-1:0] r_out_data;
   logic [2:0]       r_sel;
   logic [7:0]       w_scan;
   logic [2:0]       w_scan_idx;
   logic [2:0]       w_win;
   logic             w_any;
   logic [2:0]       w_op;
   logic [WIDTH-1:0] w_mux_out;
   logic             w_capture;
   logic             w_accept;
   logic             w_out_valid;
   logic [7:0]       w_grant;

   assign w_any = |bus.req;

`ifdef MUX_ARB_FIXED_PRIO_EN
   assign w_scan = bus.req;
   assign w_win  = w_scan_idx;
`else
   logic [2:0]  r_ptr;
   logic [15:0] w_req_dbl;

   // Rotate so that bit 0 of the scan vector is the requester at ptr.
   assign w_req_dbl = {bus.req, bus.req};
   assign w_scan    = w_req_dbl[r_ptr +: 8];
   assign w_win     = r_ptr + w_scan_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= 3'd0;
      end else if (w_accept) begin
         r_ptr <= r_sel + 3'd1;
      end
   end
`endif

   always_comb begin
      w_scan_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (w_scan[i]) begin
            w_scan_idx = 3'(i);
         end
      end
   end

   // While holding, the mux keeps pointing at the captured winner.
   assign w_op = (r_state == c_IDLE) ? w_win : r_sel;

   mux32_8 #(
      .WIDTH (WIDTH)
   ) u_mux (
      .a   (bus.a),
      .b   (bus.b),
      .c   (bus.c),
      .d   (bus.d),
      .e   (bus.e),
      .f   (bus.f),
      .g   (bus.g),
      .h   (bus.h),
      .op  (w_op),
      .out (w_mux_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_any)         w_state_nxt = c_HOLD;
         c_HOLD:  if (bus.out_ready) w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Reset masks the accept so a discarded transfer never shows a grant.
   always_comb begin
      w_capture   = 1'b0;
      w_accept    = 1'b0;
      w_out_valid = 1'b0;
      w_grant     = 8'd0;
      case (r_state)
         c_IDLE: begin
            w_capture = w_any;
         end
         c_HOLD: begin
            w_out_valid = 1'b1;
            w_accept    = bus.out_ready & ~reset;
            if (w_accept) begin
               w_grant = 8'd1 << r_sel;
            end
         end
         default: begin
            w_capture = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_data <= '0;
         r_sel      <= 3'd0;
      end else if (w_capture) begin
         r_out_data <= w_mux_out;
         r_sel      <= w_win;
      end
   end

   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.sel       = r_sel;
   assign bus.grant     = w_grant;
endmodule
`default_nettype wire

// File: tb/tb_mux32_8_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux32_8_arbiter
// Description : Directed scenarios plus randomized traffic against a
//               transaction-level model of the round-robin arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mux32_8_arbiter;
   localparam int c_WIDTH = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [c_WIDTH-1:0] src [8];
   int                checks = 0;
   int                errors = 0;

   // Model state: is a word pending, which one, who won, where the scan starts
   logic              m_valid = 1'b0;
   logic [c_WIDTH-1:0] m_data  = '0;
   int                m_sel   = 0;
   int                m_ptr   = 0;

   mux32_8_arbiter_if #(.WIDTH(c_WIDTH)) bus ();

   mux32_8_arbiter #(.WIDTH(c_WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.a = src[0];
   assign bus.b = src[1];
   assign bus.c = src[2];
   assign bus.d = src[3];
   assign bus.e = src[4];
   assign bus.f = src[5];
   assign bus.g = src[6];
   assign bus.h = src[7];

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int model_winner(input logic [7:0] r, input int p);
`ifdef MUX_ARB_FIXED_PRIO_EN
      p = 0;
`endif
      for (int i = 0; i < 8; i++) begin
         if (r[(p + i) % 8]) return (p + i) % 8;
      end
      return -1;
   endfunction

   // Compare every output with the model, then advance both by one clock.
   task automatic step();
      logic [7:0] exp_grant;
      int         w;
      #1;
      exp_grant = (m_valid && bus.out_ready && !reset) ? (8'd1 << m_sel) : 8'd0;
      check_eq("m_valid", 32'(bus.out_valid), 32'(m_valid));
      check_eq("m_data",  bus.out_data, m_data);
      check_eq("m_sel",   32'(bus.sel), 32'(m_sel));
      check_eq("m_grant", 32'(bus.grant), 32'(exp_grant));
      if (reset) begin
         m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
      end else if (!m_valid) begin
         w = model_winner(bus.req, m_ptr);
         if (w >= 0) begin
            m_valid = 1'b1; m_sel = w; m_data = src[w];
         end
      end else if (bus.out_ready) begin
         m_valid = 1'b0;
         m_ptr   = (m_sel + 1) % 8;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [31:0] d,
                             input logic [2:0] s, input logic [7:0] g);
      #1;
      check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
      check_eq({tag, "_data"},  bus.out_data, d);
      check_eq({tag, "_sel"},   32'(bus.sel), 32'(s));
      check_eq({tag, "_grant"}, 32'(bus.grant), 32'(g));
   endtask

   // Run until one word is accepted; the winner drops its request afterwards.
   task automatic xfer(output int gsel, output logic [31:0] gdata);
      bit found;
      found = 1'b0;
      gsel  = -1;
      gdata = '0;
      for (int i = 0; i < 16 && !found; i++) begin
         #1;
         if (bus.out_valid && bus.out_ready) begin
            found = 1'b1;
            gsel  = int'(bus.sel);
            gdata = bus.out_data;
         end
         step();
      end
      check_eq("xfer_found", 32'(found), 32'd1);
      if (found) bus.req[gsel] = 1'b0;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      int          s;
      logic [31:0] dv;
      logic        acc;
      int          gs;

      for (int k = 0; k < 8; k++) src[k] = '0;
      bus.req       = 8'd0;
      bus.out_ready = 1'b1;
      reset         = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      expect_out("reset", 1'b0, 32'd0, 3'd0, 8'd0);
      reset = 1'b0;

      // Single requester c
      src[2]  = 32'd15;
      bus.req = 8'b0000_0100;
      step();
      expect_out("single", 1'b1, 32'd15, 3'd2, 8'b0000_0100);
      step();
      bus.req = 8'd0;
      expect_out("single_done", 1'b0, 32'd15, 3'd2, 8'd0);

      // All eight, round-robin from ptr 0
      reset_dut();
      for (int k = 0; k < 8; k++) src[k] = 32'(k + 1);
      bus.req = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         xfer(s, dv);
         check_eq("all_sel", 32'(s), 32'(k));
         check_eq("all_data", dv, 32'(k + 1));
      end

      // Wrap behaviour around h/a
      bus.req = 8'h81;
      xfer(s, dv);
      check_eq("wrap_a_first", 32'(s), 32'd0);
      xfer(s, dv);
      check_eq("wrap_h_second", 32'(s), 32'd7);
      bus.req = 8'h40;
      xfer(s, dv);
      check_eq("wrap_g", 32'(s), 32'd6);
      bus.req = 8'h81;
      xfer(s, dv);
`ifdef MUX_ARB_FIXED_PRIO_EN
      check_eq("wrap_after_g_1", 32'(s), 32'd0);
      xfer(s, dv);
      check_eq("wrap_after_g_2", 32'(s), 32'd7);
`else
      check_eq("wrap_after_g_1", 32'(s), 32'd7);
      xfer(s, dv);
      check_eq("wrap_after_g_2", 32'(s), 32'd0);
`endif

      // Backpressure with changing data and a competing request
      reset_dut();
      src[4]        = 32'hDEADBEEF;
      bus.req       = 8'h10;
      bus.out_ready = 1'b0;
      step();
      for (int n = 0; n < 5; n++) begin
         src[4]     = $urandom;
         bus.req[0] = 1'b1;
         expect_out("bp_hold", 1'b1, 32'hDEADBEEF, 3'd4, 8'd0);
         step();
      end
      bus.out_ready = 1'b1;
      expect_out("bp_accept", 1'b1, 32'hDEADBEEF, 3'd4, 8'h10);
      step();
      bus.req[4] = 1'b0;
      xfer(s, dv);
      check_eq("bp_next", 32'(s), 32'd0);

      // Reset while holding
      bus.req = 8'h40;
      xfer(s, dv);
      src[3]        = 32'h1234_5678;
      bus.req       = 8'h08;
      bus.out_ready = 1'b0;
      step();
      expect_out("rst_pre", 1'b1, 32'h1234_5678, 3'd3, 8'd0);
      reset         = 1'b1;
      bus.out_ready = 1'b1;
      expect_out("rst_in_hold", 1'b1, 32'h1234_5678, 3'd3, 8'd0);
      step();
      reset   = 1'b0;
      bus.req = 8'd0;
      expect_out("rst_after", 1'b0, 32'd0, 3'd0, 8'd0);
      bus.req = 8'h81;
      xfer(s, dv);
      check_eq("rst_ptr0", 32'(s), 32'd0);
      bus.req = 8'd0;

`ifdef MUX_ARB_FIXED_PRIO_EN
      bus.req = 8'h21;
      for (int n = 0; n < 4; n++) begin
         xfer(s, dv);
         check_eq("fixed_a", 32'(s), 32'd0);
         bus.req[0] = 1'b1;
      end
      bus.req = 8'd0;
`endif

      // Randomized traffic
      reset_dut();
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < 8; k++) src[k] = $urandom;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         reset         = ($urandom_range(0, 63) == 0);
         bus.req       = bus.req | (8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)));
         acc           = m_valid && bus.out_ready && !reset;
         gs            = m_sel;
         step();
         if (acc) bus.req[gs] = 1'b0;
      end
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mux32_8_arbiter.md
# mux32_8_arbiter

Round-robin scheduler that shares one `mux32_8` (eight 32-bit inputs `a`..`h`, 3-bit `op` select) among eight requesters. Each cycle it picks one pending requester, drives the mux select, and captures the selected word into an output register. The captured word is offered downstream with a valid/ready handshake. The block sits between the eight datapath sources and the single consumer of the shared 32-bit bus.

## Interface
- `WIDTH`, 32, data width of each input and of `out_data` (the internal `mux32_8` instance is used at 32).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  8  request per source; bit 0 = `a` … bit 7 = `h`.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`,`h`  in  WIDTH each  source data words.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_valid`  out  1  `out_data` holds a granted word.
- `out_data`  out  WIDTH  captured mux output.
- `sel`  out  3  registered select of the current or last winner; equals mux `op`.
- `grant`  out  8  one-hot acknowledge. Combinational: `grant[sel] = out_valid & out_ready`, all other bits 0.

## Operation
- State machine: `IDLE`, `HOLD`. Round-robin pointer `ptr[2:0]`.
- `IDLE`, `req == 0`: no change, `out_valid = 0`.
- `IDLE`, `req != 0`:
  - Winner `w` = first set `req` bit searching `ptr, ptr+1, …, 7, 0, …, ptr-1`.
  - On the edge: `sel <= w`, `out_data <=` mux output with `op = w`, `out_valid <= 1`, go to `HOLD`.
- `HOLD`, `out_ready = 0`: `out_data`, `sel`, `out_valid` frozen. Input changes are ignored.
- `HOLD`, `out_ready = 1`:
  - `grant[sel]` pulses this cycle.
  - On the edge: `out_valid <= 0`, `ptr <= sel + 1` mod 8 (7 wraps to 0), go to `IDLE`.
- A requester must keep `req` high until it sees its `grant`, and must drop `req` on the edge after `grant`. Data is sampled only on the grant-selection edge; the source may change it any time after that.
- If a requester drops `req` while in `HOLD`, the transfer still completes with the captured word.
- `req` changes during `HOLD` do not affect the current winner.
- Inputs are always passed through the `mux32_8` instance. No bypass path.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `sel = 0`, `grant = 0`, `ptr = 0`, state `IDLE`.
- Latency: `req` sampled high at edge N → `out_valid = 1` and `out_data` valid from edge N (visible in cycle N+1).
- Throughput: at most one transfer per 2 cycles (`IDLE` → `HOLD` → `IDLE`).
- Accept happens in the cycle where `out_valid & out_ready` are both high. `grant` is high in that same cycle only.
- Reset in `HOLD`: transfer is discarded, no `grant` issued, `ptr` returns to 0. Reset has priority over every other event.
- `out_ready` high while `out_valid = 0`: no effect.

## Configuration
- `MUX_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. The winner is the lowest-index set `req` bit (`a` highest). `ptr` is not implemented; `sel` still registers the winner.
  - Undefined (default): round-robin as described above.

## Test plan
- Only `req[2]` high, `c = 15`, all other inputs 0, `out_ready = 1` → `out_valid = 1`, `sel = 2`, `out_data = 15` one cycle later. `grant = 8'b0000_0100` in that cycle. `out_valid = 0` on the following cycle.
- All eight `req` high, `a..h = 1..8`, each source drops `req` after its grant, `out_ready = 1` → `out_data` sequence 1,2,…,8 with `sel` 0..7, one transfer every 2 cycles. Then `ptr = 0`.
- Wrap: after granting `h` (`ptr = 0`), assert `req[7]` and `req[0]` → `a` wins first. After granting `g` (`ptr = 7`), assert `req[7]` and `req[0]` → `h` wins, then `a`.
- Backpressure: winner `e = 0xDEADBEEF`, `out_ready = 0` for 5 cycles, while changing `e` and asserting `req[0]` → `out_data`, `sel = 4`, `out_valid = 1` stable and `grant = 0`. Raising `out_ready` → `grant[4]` pulses, then source 0 wins next.
- Reset asserted in `HOLD` → next cycle `out_valid = 0`, `out_data = 0`, `sel = 0`, no `grant`. The next arbitration starts from `ptr = 0`.
- With `MUX_ARB_FIXED_PRIO_EN` defined, `req[0]` and `req[5]` held continuously → `a` wins every transfer, `f` never granted.
